collatz_step: RTL

- Responder end of the go/done iterator handshake used by the count-range driver.
- Accepts a 32-bit start value on `go` and iterates the Collatz map one step per clock until the value reaches 1.
- Reports the step count, the current value, the peak value, and an overflow/error flag.
- Holds `done` high until the next `go`, so a driver can sample `done` and immediately re-issue `go` for the next start value.

---
 rtl/collatz_step.sv | 134 +++++++++++++
 1 files changed

// File: rtl/collatz_step.sv
// Collatz iterator: loads n on go, applies one map step per clock until 1, 0 or 3x+1 overflow.
// Latency: done rises on edge S+1 after the go edge (S = steps taken); go restarts from any state.
// Backpressure: none; done holds until the next go. Build option COLLATZ_PEAK_EN enables peak tracking.
module collatz_step #(
  parameter int STEP_BITS = 16,
  parameter int DATA_BITS = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 go,
  input  logic [DATA_BITS-1:0] n,
  output logic                 busy,
  output logic                 done,
  output logic [DATA_BITS-1:0] dout,
  output logic [STEP_BITS-1:0] steps,
  output logic [DATA_BITS-1:0] peak,
  output logic                 err
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  localparam logic [DATA_BITS-1:0] ONE = {{(DATA_BITS-1){1'b0}}, 1'b1};

  state_t                 state, state_nxt;
  logic                   busy_nxt, done_nxt, err_nxt;
  logic [DATA_BITS-1:0]   dout_nxt;
  logic [STEP_BITS-1:0]   steps_nxt, steps_inc;
  logic [DATA_BITS+1:0]   triple;
  logic                   fits;
  logic                   grow;

  // 3x+1 as (2x+1)+x, two extra bits so overflow is visible
  assign triple    = {1'b0, dout, 1'b1} + {2'b00, dout};
  assign fits      = (triple[DATA_BITS+1:DATA_BITS] == 2'b00);
  // step counter sticks at all-ones; iteration keeps going
  assign steps_inc = (&steps) ? steps : steps + 1'b1;
  // true on a RUN edge that takes a legal odd step (peak may move)
  assign grow      = (state == RUN) && !go && dout[0] && (dout != ONE) && fits;

  // state and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      dout  <= '0;
      steps <= '0;
    end else begin
      state <= state_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
      err   <= err_nxt;
      dout  <= dout_nxt;
      steps <= steps_nxt;
    end
  end

  // next state and outputs; go overrides everything in every state
  always_comb begin
    state_nxt = state;
    busy_nxt  = busy;
    done_nxt  = done;
    err_nxt   = err;
    dout_nxt  = dout;
    steps_nxt = steps;
    if (go) begin
      state_nxt = RUN;
      busy_nxt  = 1'b1;
      done_nxt  = 1'b0;
      err_nxt   = 1'b0;
      dout_nxt  = n;
      steps_nxt = '0;
    end else begin
      case (state)
        RUN: begin
          if ((dout == ONE) || (dout == '0)) begin
            // terminal value: 1 is normal, 0 can never converge
            state_nxt = FIN;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            err_nxt   = (dout == '0);
          end else if (!dout[0]) begin
            dout_nxt  = dout >> 1;
            steps_nxt = steps_inc;
          end else if (fits) begin
            dout_nxt  = triple[DATA_BITS-1:0];
            steps_nxt = steps_inc;
          end else begin
            // 3x+1 would not fit: stop with the last legal value held
            state_nxt = FIN;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            err_nxt   = 1'b1;
          end
        end
        default: begin
          // IDLE and FIN simply hold until the next go
        end
      endcase
    end
  end

`ifdef COLLATZ_PEAK_EN
  logic [DATA_BITS-1:0] peak_q, peak_nxt;

  // running maximum, seeded with the start value
  always_comb begin
    peak_nxt = peak_q;
    if (go) begin
      peak_nxt = n;
    end else if (grow && (triple[DATA_BITS-1:0] > peak_q)) begin
      peak_nxt = triple[DATA_BITS-1:0];
    end
  end

  // peak register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      peak_q <= '0;
    end else begin
      peak_q <= peak_nxt;
    end
  end

  assign peak = peak_q;
`else
  // no peak tracking in this build; grow is only needed by the tracker
  logic unused_grow;
  assign unused_grow = grow;
  assign peak        = '0;
`endif

endmodule
